// File: rtl/mips_pkg.sv
// mips_pkg: shared types for the MIPS core's multiply/divide unit.
//   md_op_t    : E-stage multiply/divide opcode (bit 1 = divide, bit 0 = unsigned)
//   md_state_t : iterative unit sequencing states
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: bundle between the pipeline and the multiply/divide unit.
//   startE/opE/srcaE/srcbE : op launch from E stage
//   kill                   : abort in-flight op
//   hlweW/hlselW/hlwdW     : mthi/mtlo write from W stage
//   busy/done/hi/lo        : status and architectural HI/LO back to the pipeline
// master = pipeline side, slave = mult_div_unit.
interface mult_div_unit_if
  import mips_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            startE;
  md_op_t          opE;
  logic [XLEN-1:0] srcaE;
  logic [XLEN-1:0] srcbE;
  logic            kill;
  logic            hlweW;
  logic            hlselW;
  logic [XLEN-1:0] hlwdW;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output startE, opE, srcaE, srcbE, kill, hlweW, hlselW, hlwdW,
    input  busy, done, hi, lo
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, kill, hlweW, hlselW, hlwdW,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem     in  XLEN  partial remainder (always < divisor)
//   dbit    in  1     next dividend bit shifted in
//   divisor in  XLEN  divisor magnitude
//   remNxt  out XLEN  updated partial remainder
//   qBit    out 1     quotient bit produced by this iteration
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dbit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] remNxt,
  output logic            qBit
);
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  assign shifted = {rem, dbit};
  // When the subtraction succeeds the result is below the divisor, so the
  // low XLEN bits of the modular difference are exact.
  assign diff    = {rem[XLEN-2:0], dbit} - divisor;
  assign qBit    = (shifted >= {1'b0, divisor});
  assign remNxt  = qBit ? diff : shifted[XLEN-1:0];
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   md     slave side of mult_div_unit_if (launch, kill, mthi/mtlo, busy/done/hi/lo)
// Operands are reduced to magnitudes at launch, XLEN iterations run on a
// shared 2*XLEN accumulator, and signs are restored in the FIX cycle when
// HI/LO are written. Op takes XLEN+1 busy cycles after the launch edge.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave md
);
  localparam int CW = $clog2(XLEN);

  md_state_t         state, stateNxt;
  logic [CW-1:0]     cnt;
  logic              isDivR, negRes, negRem, divZero;
  logic [XLEN-1:0]   bMag;
  // Upper half: multiply partial sum / division remainder.
  // Lower half: remaining multiplier bits / dividend shifting into quotient.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   hiR, loR;

  // ---- launch-time operand conditioning ----
  logic            sgnE, aSgn, bSgn;
  logic [XLEN-1:0] aMagE, bMagE;
  assign sgnE  = ~md.opE[0];
  assign aSgn  = sgnE & md.srcaE[XLEN-1];
  assign bSgn  = sgnE & md.srcbE[XLEN-1];
  assign aMagE = aSgn ? -md.srcaE : md.srcaE;
  assign bMagE = bSgn ? -md.srcbE : md.srcbE;

  // ---- iteration datapath ----
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] accMulNxt, accDivNxt;
  logic [XLEN-1:0]   remNxt;
  logic              qBit;

  assign mulSum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, bMag} : '0);
  assign accMulNxt = {mulSum, acc[XLEN-1:1]};

  div_step #(.XLEN(XLEN)) uStep (
    .rem    (acc[2*XLEN-1:XLEN]),
    .dbit   (acc[XLEN-1]),
    .divisor(bMag),
    .remNxt (remNxt),
    .qBit   (qBit)
  );
  assign accDivNxt = {remNxt, acc[XLEN-2:0], qBit};

  // ---- sign fixup for the FIX write ----
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quo, rmd, quoFix, rmdFix, resHi, resLo;
  assign prodFix = negRes ? -acc : acc;
  assign quo     = acc[XLEN-1:0];
  assign rmd     = acc[2*XLEN-1:XLEN];
  // Divide by zero leaves the dividend magnitude in the remainder, so the
  // usual remainder sign restore reproduces the raw dividend in HI.
  assign quoFix  = divZero ? '1 : (negRes ? -quo : quo);
  assign rmdFix  = negRem ? -rmd : rmd;
  assign resHi   = isDivR ? rmdFix : prodFix[2*XLEN-1:XLEN];
  assign resLo   = isDivR ? quoFix : prodFix[XLEN-1:0];

  // ---- FSM ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MD_IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      MD_IDLE: if (md.startE) stateNxt = MD_RUN;
      MD_RUN:  if (md.kill) stateNxt = MD_IDLE;
               else if (cnt == CW'(XLEN-1)) stateNxt = MD_FIX;
      MD_FIX:  stateNxt = MD_IDLE;
      default: stateNxt = MD_IDLE;
    endcase
  end

  // ---- datapath registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      isDivR  <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      bMag    <= '0;
      acc     <= '0;
    end else if (state == MD_IDLE && md.startE) begin
      cnt     <= '0;
      isDivR  <= md.opE[1];
      negRes  <= aSgn ^ bSgn;
      negRem  <= aSgn;
      divZero <= md.opE[1] & (md.srcbE == '0);
      bMag    <= bMagE;
      acc     <= {{XLEN{1'b0}}, aMagE};
    end else if (state == MD_RUN) begin
      cnt     <= cnt + CW'(1);
      acc     <= isDivR ? accDivNxt : accMulNxt;
    end
  end

  // ---- HI/LO: mthi/mtlo is the younger instruction and wins its register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hiR <= '0;
      loR <= '0;
    end else begin
      if (state == MD_FIX && !md.kill) begin
        hiR <= resHi;
        loR <= resLo;
      end
      if (md.hlweW) begin
        if (md.hlselW) hiR <= md.hlwdW;
        else           loR <= md.hlwdW;
      end
    end
  end

  assign md.busy = (state != MD_IDLE);
  assign md.done = (state == MD_FIX) & ~md.kill;
  assign md.hi   = hiR;
  assign md.lo   = loR;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed results, plus a
// cycle model (op countdown + arithmetic reference) compared every cycle.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_div_unit_if #(.XLEN(32)) mdIf ();

  mult_div_unit #(.XLEN(32)) dut (
    .clk  (clk),
    .reset(rst_n),
    .md   (mdIf)
  );

  int nChk = 0;
  int nPass = 0;
  bit live = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] mdRef(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Model: an op occupies 33 cycles after its launch edge; result lands at the
  // end of the last one unless killed; mthi/mtlo overrides its register.
  int          mLeft;
  logic [63:0] mRes;
  logic [31:0] mHi, mLo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mLeft <= 0;
      mRes  <= '0;
      mHi   <= '0;
      mLo   <= '0;
    end else begin
      if (mLeft > 0) begin
        if (mdIf.kill) mLeft <= 0;
        else if (mLeft == 1) begin
          mLeft <= 0;
          mHi   <= mRes[63:32];
          mLo   <= mRes[31:0];
        end else mLeft <= mLeft - 1;
      end else if (mdIf.startE) begin
        mLeft <= 33;
        mRes  <= mdRef(mdIf.opE, mdIf.srcaE, mdIf.srcbE);
      end
      if (mdIf.hlweW) begin
        if (mdIf.hlselW) mHi <= mdIf.hlwdW;
        else             mLo <= mdIf.hlwdW;
      end
    end
  end

  always @(negedge clk) begin
    if (live && rst_n) begin
      chk("cyc busy", 32'(mdIf.busy), 32'(mLeft > 0));
      chk("cyc done", 32'(mdIf.done), 32'((mLeft == 1) && !mdIf.kill));
      chk("cyc hi", mdIf.hi, mHi);
      chk("cyc lo", mdIf.lo, mLo);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Launch at cycle 0, then track busy/done until idle. hlAt: cycle in which
  // to assert an mtlo of hlData (-1 for none).
  task automatic runOp(input string nm, input md_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo,
                       input int hlAt, input logic [31:0] hlData);
    int busyN, doneAt;
    mdIf.startE = 1'b1;
    mdIf.opE    = op;
    mdIf.srcaE  = a;
    mdIf.srcbE  = b;
    cyc();
    mdIf.startE = 1'b0;
    busyN  = 0;
    doneAt = -1;
    for (int k = 1; k <= 40; k++) begin
      if (mdIf.busy) busyN++;
      if (mdIf.done) doneAt = k;
      if (!mdIf.busy) break;
      if (k == hlAt) begin
        mdIf.hlweW  = 1'b1;
        mdIf.hlselW = 1'b0;
        mdIf.hlwdW  = hlData;
      end
      cyc();
      mdIf.hlweW = 1'b0;
    end
    chk({nm, " busyCycles"}, 32'(busyN), 32'd33);
    chk({nm, " doneCycle"}, 32'(doneAt), 32'd33);
    chk({nm, " hi"}, mdIf.hi, eHi);
    chk({nm, " lo"}, mdIf.lo, eLo);
  endtask

  initial begin
    bit sawDone;
    rst_n       = 1'b0;
    mdIf.startE = 1'b0;
    mdIf.opE    = MD_MULT;
    mdIf.srcaE  = '0;
    mdIf.srcbE  = '0;
    mdIf.kill   = 1'b0;
    mdIf.hlweW  = 1'b0;
    mdIf.hlselW = 1'b0;
    mdIf.hlwdW  = '0;
    #12;
    chk("reset busy", 32'(mdIf.busy), 32'd0);
    chk("reset done", 32'(mdIf.done), 32'd0);
    chk("reset hi", mdIf.hi, 32'd0);
    chk("reset lo", mdIf.lo, 32'd0);
    cyc();
    rst_n = 1'b1;
    live  = 1'b1;
    cyc();

    runOp("MULT -2*3",   MD_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, -1, 0);
    runOp("MULTU",       MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, -1, 0);
    runOp("DIV -7/2",    MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 0);
    runOp("DIV 7/-2",    MD_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, -1, 0);
    runOp("DIVU 7/2",    MD_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, -1, 0);
    runOp("DIVU 5/0",    MD_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, -1, 0);
    runOp("DIV -7/0",    MD_DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1, 0);
    runOp("MULTU max",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, 0);
    runOp("DIV ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1, 0);

    // Kill mid-op, with an ignored second launch while busy.
    mdIf.startE = 1'b1;
    mdIf.opE    = MD_MULT;
    mdIf.srcaE  = 32'd5;
    mdIf.srcbE  = 32'd7;
    cyc();
    mdIf.startE = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) begin
        mdIf.startE = 1'b1;
        mdIf.opE    = MD_DIVU;
        mdIf.srcaE  = 32'd9;
        mdIf.srcbE  = 32'd2;
      end
      if (k == 10) mdIf.kill = 1'b1;
      cyc();
      mdIf.startE = 1'b0;
      mdIf.kill   = 1'b0;
    end
    chk("kill busy@11", 32'(mdIf.busy), 32'd0);
    sawDone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mdIf.done) sawDone = 1'b1;
      cyc();
    end
    chk("kill noDone", 32'(sawDone), 32'd0);
    chk("kill hi", mdIf.hi, 32'd0);
    chk("kill lo", mdIf.lo, 32'h8000_0000);

    // mtlo on the FIX edge: LO from the move, HI from the product.
    runOp("MULT+mtlo", MD_MULT, 32'd2, 32'd3, 32'd0, 32'h0000_1234, 33, 32'h0000_1234);

    // Asynchronous reset mid-op.
    mdIf.startE = 1'b1;
    mdIf.opE    = MD_MULT;
    mdIf.srcaE  = 32'd7;
    mdIf.srcbE  = 32'd9;
    cyc();
    mdIf.startE = 1'b0;
    for (int k = 1; k < 5; k++) cyc();
    chk("pre-reset busy", 32'(mdIf.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async busy", 32'(mdIf.busy), 32'd0);
    chk("async hi", mdIf.hi, 32'd0);
    chk("async lo", mdIf.lo, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post-reset done", 32'(mdIf.done), 32'd0);
    cyc();

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
